prog_sequencer: RTL and testbench

//  Test-run sequencer directly upstream of the processor top: owns the DUT's start (init/reset)
//  and consumes its halt flag. Runs NUM_PROGS programs back to back, selects each via prog_sel,
//  and counts executed cycles per program. Reports one count per program; aborts on a hung program.

---
 rtl/prog_sequencer.sv | 106 ++++++++++
 tb/tb_prog_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Test-run sequencer: holds the processor in init, releases it per program, counts run cycles
// until halt, reports one count per program, and aborts the sequence on a hung program.
module prog_sequencer #(
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned CW           = 16,
  parameter int unsigned TIMEOUT      = 16'hFFFF,
  localparam int unsigned PW          = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          go,
  input  logic          dut_halt,
  output logic          dut_start,
  output logic [PW-1:0] prog_sel,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          cyc_valid,
  output logic [CW-1:0] cyc_count,
  output logic [PW-1:0] cyc_prog
);

  // state  | meaning
  // IDLE   | waiting for go, processor held in init
  // ASSERT | dut_start held for START_CYCLES cycles
  // RUN    | processor running, counting non-halt cycles
  // REPORT | one-cycle cyc_valid pulse with the count
  // DONE   | sequence finished, processor state preserved
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ASSERT = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SW-1:0] ST_LOAD   = SW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST_PROG = PW'(NUM_PROGS - 1);

  logic [2:0]    state;
  logic [SW-1:0] st_cnt;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      prog_sel  <= '0;
      st_cnt    <= '0;
      run_cnt   <= '0;
      timeout   <= 1'b0;
      cyc_count <= '0;
      cyc_prog  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state    <= S_ASSERT;
            prog_sel <= '0;
            timeout  <= 1'b0;
            st_cnt   <= ST_LOAD;
          end
        end
        S_ASSERT: begin
          if (st_cnt == '0) begin
            state   <= S_RUN;
            run_cnt <= '0;
          end else begin
            st_cnt <= st_cnt - 1'b1;
          end
        end
        S_RUN: begin
          // halt takes priority over the timeout limit in the same cycle
          if (dut_halt) begin
            state     <= S_REPORT;
            cyc_count <= run_cnt;
            cyc_prog  <= prog_sel;
          end else if (run_cnt == TO_LIMIT) begin
            state     <= S_REPORT;
            timeout   <= 1'b1;
            cyc_count <= run_cnt;
            cyc_prog  <= prog_sel;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (timeout || prog_sel == LAST_PROG) begin
            state <= S_DONE;
          end else begin
            state    <= S_ASSERT;
            prog_sel <= prog_sel + 1'b1;
            st_cnt   <= ST_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dut_start = (state == S_IDLE) || (state == S_ASSERT);
  assign busy      = (state == S_ASSERT) || (state == S_RUN) || (state == S_REPORT);
  assign done      = (state == S_DONE);
  assign cyc_valid = (state == S_REPORT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a simple processor model halts after a per-program cycle count;
// reports are compared against an expected list computed from the sequencing rules.
module tb_prog_sequencer;
  localparam int NP = 3;
  localparam int CWB = 8;
  localparam int TO = 30;
  localparam int PWB = 2;
  localparam logic [7:0] NEVER = 8'hFF;

  logic CLK = 1'b0;
  logic reset, go;
  logic dut_halt, dut_start, busy, done, timeout, cyc_valid;
  logic [PWB-1:0] prog_sel, cyc_prog;
  logic [CWB-1:0] cyc_count;

  int n_chk = 0;
  int n_fail = 0;

  prog_sequencer #(.NUM_PROGS(NP), .START_CYCLES(2), .CW(CWB), .TIMEOUT(TO)) dut (
    .CLK(CLK), .reset(reset), .go(go), .dut_halt(dut_halt), .dut_start(dut_start),
    .prog_sel(prog_sel), .busy(busy), .done(done), .timeout(timeout),
    .cyc_valid(cyc_valid), .cyc_count(cyc_count), .cyc_prog(cyc_prog)
  );

  always #5 CLK = ~CLK;

  // processor model: held while dut_start, then halts after lens[prog] cycles and stays halted
  logic [7:0] lens [NP];
  logic [7:0] proc_cnt;
  always @(posedge CLK) begin
    if (dut_start) proc_cnt <= 8'd0;
    else if (proc_cnt != 8'hFF) proc_cnt <= proc_cnt + 8'd1;
  end
  assign dut_halt = !dut_start && (proc_cnt >= lens[prog_sel]);

  // monitor: cyc_valid reports and lengths of dut_start-high stretches while busy
  logic [15:0] rep_q[$];
  int st_q[$];
  int st_run = 0;
  int pulses = 0;
  always @(negedge CLK) begin
    if (reset) begin
      st_run = 0;
    end else begin
      if (cyc_valid) begin
        rep_q.push_back({8'(cyc_prog), 8'(cyc_count)});
        pulses++;
      end
      if (busy && dut_start) st_run++;
      else if (st_run != 0) begin
        st_q.push_back(st_run);
        st_run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
  endtask

  // runs one full sequence and checks it against the rule-derived expectation
  task automatic run_seq(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                         input bit go_mid);
    logic [15:0] exp_q[$];
    logic [7:0] l [NP];
    bit exp_to;
    bit go_done;
    bit got_done;
    l[0] = l0; l[1] = l1; l[2] = l2;
    lens = l;
    exp_to = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (int'(l[p]) > TO) begin
        exp_q.push_back({8'(p), 8'(TO)});
        exp_to = 1'b1;
        break;
      end
      exp_q.push_back({8'(p), l[p]});
    end
    rep_q.delete();
    st_q.delete();
    @(negedge CLK);
    pulse_go();
    chk("go_busy", busy, 1);
    chk("go_done_low", done, 0);
    chk("go_timeout_clr", timeout, 0);
    chk("go_prog0", prog_sel, 0);
    chk("go_start", dut_start, 1);
    go_done = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (go_mid && !go_done && busy && !dut_start && !cyc_valid) begin
        go_done = 1'b1;
        pulse_go();
      end else begin
        @(negedge CLK);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("done_reached", got_done, 1);
    chk("timeout_flag", timeout, exp_to);
    chk("report_count", rep_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rep_q.size(); i++)
      chk($sformatf("report%0d", i), rep_q[i], exp_q[i]);
    chk("start_count", st_q.size(), exp_q.size());
    foreach (st_q[i]) chk($sformatf("start_len%0d", i), st_q[i], 2);
    repeat (3) @(negedge CLK);
    chk("done_hold", done, 1);
    chk("done_start_low", dut_start, 0);
    chk("hold_count", cyc_count, exp_q[exp_q.size()-1][7:0]);
    chk("hold_prog", cyc_prog, exp_q[exp_q.size()-1][15:8]);
    chk("no_extra_report", rep_q.size(), exp_q.size());
  endtask

  initial begin
    int pbefore;
    bit in_run;
    logic [7:0] a, b, c;
    reset = 1'b1;
    go = 1'b0;
    for (int i = 0; i < NP; i++) lens[i] = 8'd5;
    repeat (3) @(negedge CLK);
    chk("rst_start", dut_start, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_valid", cyc_valid, 0);
    chk("rst_count", cyc_count, 0);
    chk("rst_cprog", cyc_prog, 0);
    chk("rst_psel", prog_sel, 0);
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    chk("idle_start", dut_start, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_pulses", pulses, 0);

    run_seq(8'd10, 8'd25, 8'd7, 1'b0);
    run_seq(8'd5, NEVER, 8'd9, 1'b0);
    // go from DONE after a timeout: done falls and timeout clears on the next cycle
    run_seq(8'd0, 8'd30, 8'd3, 1'b0);
    run_seq(8'd12, 8'd4, 8'd31, 1'b1);
    run_seq(8'd6, 8'd6, 8'd6, 1'b1);

    // reset in the middle of program 1's RUN
    lens[0] = 8'd4; lens[1] = NEVER; lens[2] = 8'd4;
    pulse_go();
    in_run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (prog_sel == 2'd1 && busy && !dut_start) begin
        in_run = 1'b1;
        break;
      end
    end
    chk("reach_run1", in_run, 1);
    repeat (3) @(negedge CLK);
    pbefore = pulses;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_start", dut_start, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_psel", prog_sel, 0);
    chk("mid_rst_valid", cyc_valid, 0);
    chk("mid_rst_done", done, 0);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_rst_no_report", pulses, pbefore);
    run_seq(8'd3, 8'd8, 8'd2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      a = 8'($urandom_range(0, 34));
      b = 8'($urandom_range(0, 34));
      c = 8'($urandom_range(0, 34));
      run_seq(a, b, c, ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
